// File: rtl/mont_red_pkg.sv
// rtl/mont_red_pkg.sv - shared types and elaboration helpers for the Montgomery reduction stage
package mont_red_pkg;

    typedef enum logic [1:0] {IDLE, RED, FIN, DONE} mont_red_state_t;

    function automatic int mont_k(input int logq, input int w);
        return (logq + w - 1) / w;
    endfunction

    function automatic int mont_lat(input int logq, input int w);
        return mont_k(logq, w) + 1;
    endfunction

    // Seed x=q is already q^-1 mod 8 for odd q; each Newton step doubles the correct bits.
    function automatic logic [63:0] mont_qinv(input logic [63:0] q, input int w);
        logic [63:0] x;
        logic [63:0] mask;
        x = q;
        for (int i = 0; i < 6; i++) begin
            x = x * (64'd2 - q * x);
        end
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (64'd0 - x) & mask;
    endfunction

endpackage

// File: rtl/mont_red_step.sv
// rtl/mont_red_step.sv - one combinational W-bit Montgomery digit step
module mont_red_step
    import mont_red_pkg::*;
#(
    parameter int               LOGQ = 60,
    parameter int               W    = 16,
    parameter int               LOGT = 2 * LOGQ,
    parameter logic [LOGQ-1:0]  Q    = LOGQ'(60'h0FFF_FFFF_FFFC_0001),
    parameter logic [W-1:0]     QINV = W'(mont_qinv(64'(Q), W))
) (
    input  logic [LOGT:0] acc_i,
    output logic [LOGT:0] acc_o
);

    localparam int AW = LOGT + 1;

    logic [W-1:0]  q;
    logic [AW-1:0] sum;

    // q makes the low digit of acc + q*Q zero, so the shift is exact.
    assign q     = acc_i[W-1:0] * QINV;
    assign sum   = acc_i + AW'(q) * AW'(Q);
    assign acc_o = sum >> W;

endmodule

// File: rtl/mont_red_seq.sv
// rtl/mont_red_seq.sv - word-serial Montgomery reduction T*R^-1 mod Q with valid/ready handshakes
module mont_red_seq
    import mont_red_pkg::*;
#(
    parameter int               LOGQ = 60,
    parameter int               W    = 16,
    parameter int               LOGT = 2 * LOGQ,
    parameter logic [LOGQ-1:0]  Q    = LOGQ'(60'h0FFF_FFFF_FFFC_0001),
    parameter logic [W-1:0]     QINV = W'(mont_qinv(64'(Q), W))
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGT-1:0] in_t,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_c
);

    localparam int K  = mont_k(LOGQ, W);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int AW = LOGT + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    mont_red_state_t state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d, acc_step;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LOGQ-1:0] out_c_q, out_c_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    mont_red_step #(
        .LOGQ (LOGQ),
        .W    (W),
        .LOGT (LOGT),
        .Q    (Q),
        .QINV (QINV)
    ) u_step (
        .acc_i (acc_q),
        .acc_o (acc_step)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_c_d     = out_c_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    acc_d   = AW'(in_t);
                    cnt_d   = '0;
                    state_d = RED;
                end
            end
            RED: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // acc < 2Q here, so one conditional subtract lands in [0, Q-1].
                out_c_d     = (acc_q >= AW'(Q)) ? (acc_q[LOGQ-1:0] - Q) : acc_q[LOGQ-1:0];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_c_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_c_q     <= out_c_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;

endmodule

// File: tb/tb_mont_red_seq.sv
// tb/tb_mont_red_seq.sv - directed and random scoreboard bench for mont_red_seq
module tb_mont_red_seq;

    localparam logic [4:0]  SQ   = 5'd17;
    localparam logic [59:0] BQ   = 60'h0FFF_FFFF_FFFC_0001;
    localparam int          NVEC = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [9:0]  s_in_t;
    logic [4:0]  s_out_c;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [119:0] b_in_t;
    logic [59:0] b_out_c;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [4:0]  sb_s[$];
    logic [59:0] sb_b[$];

    always #5 clk = ~clk;

    mont_red_seq #(
        .LOGQ (5),
        .W    (4),
        .LOGT (10),
        .Q    (SQ)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_t      (s_in_t),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_c     (s_out_c)
    );

    mont_red_seq u_big (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_t      (b_in_t),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_c     (b_out_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_total++;
        n_fail++;
        $error("FAIL %s: timeout waiting for DUT, observed none expected handshake", tag);
    endtask

    task automatic s_accept(input logic [9:0] t);
        int n;
        n = 0;
        s_in_valid = 1'b1;
        s_in_t     = t;
        while (!s_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_in_ready) timeout("s_accept");
        tick();
        s_in_valid = 1'b0;
        sb_s.push_back(5'(32'(t) % 32'd17));
    endtask

    task automatic s_wait_out(input string tag);
        int n;
        n = 0;
        while (!s_out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!s_out_valid) timeout(tag);
    endtask

    task automatic s_pop_check(input string tag);
        if (sb_s.size() == 0) timeout(tag);
        else check(tag, 128'(s_out_c), 128'(sb_s.pop_front()));
    endtask

    task automatic run_small(input logic [9:0] t, input string tag);
        s_accept(t);
        s_wait_out(tag);
        s_pop_check(tag);
        tick();
    endtask

    initial begin
        int           n;
        int           seen;
        bit           done;
        logic [127:0] inv2, rinv, r, exp128;

        rst = 1'b1;
        s_in_valid = 1'b0; s_in_t = '0; s_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_t = '0; b_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", 128'(s_in_ready), 128'(1'b1));
        check("reset_out_valid", 128'(s_out_valid), 128'(1'b0));
        check("reset_out_c", 128'(s_out_c), 128'(5'd0));

        // Scenario 1: maximum 10-bit T, final subtract taken
        s_accept(10'd1023);
        tick();
        check("s1_acc_iter1", 128'(u_small.acc_q), 128'(65));
        check("s1_busy_in_ready", 128'(s_in_ready), 128'(1'b0));
        tick();
        check("s1_acc_iter2", 128'(u_small.acc_q), 128'(20));
        check("s1_no_early_valid", 128'(s_out_valid), 128'(1'b0));
        n = 2;
        while (!s_out_valid && n < 50) begin
            tick();
            n++;
        end
        check("s1_latency", 128'(n), 128'(3));
        s_pop_check("s1_out_c");
        tick();
        check("s1_valid_drop", 128'(s_out_valid), 128'(1'b0));
        check("s1_ready_back", 128'(s_in_ready), 128'(1'b1));

        // Scenarios 2 and 3
        run_small(10'd33, "s2_t33");
        run_small(10'd0, "s2_t0");
        run_small(10'd272, "s3_t272");
        run_small(10'd256, "s3_t256");

        // Scenario 4: backpressure with a second request held upstream
        s_out_ready = 1'b0;
        s_accept(10'd500);
        s_wait_out("s4_wait");
        s_in_valid = 1'b1;
        s_in_t     = 10'd200;
        for (int i = 0; i < 5; i++) begin
            check("s4_hold_valid", 128'(s_out_valid), 128'(1'b1));
            check("s4_hold_c", 128'(s_out_c), 128'(5'd7));
            check("s4_hold_in_ready", 128'(s_in_ready), 128'(1'b0));
            tick();
        end
        s_pop_check("s4_out_c_first");
        s_out_ready = 1'b1;
        tick();
        check("s4_valid_drop", 128'(s_out_valid), 128'(1'b0));
        check("s4_ready_rise", 128'(s_in_ready), 128'(1'b1));
        tick();
        s_in_valid = 1'b0;
        sb_s.push_back(5'd13);
        check("s4_second_taken", 128'(s_in_ready), 128'(1'b0));
        s_wait_out("s4_wait2");
        s_pop_check("s4_out_c_second");
        tick();

        // Scenario 5: reset in the middle of RED
        s_accept(10'd1023);
        tick();
        check("s5_cnt_before_rst", 128'(u_small.cnt_q), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb_s.pop_back());
        check("s5_in_ready", 128'(s_in_ready), 128'(1'b1));
        check("s5_out_valid", 128'(s_out_valid), 128'(1'b0));
        check("s5_out_c", 128'(s_out_c), 128'(5'd0));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (s_out_valid) seen++;
            tick();
        end
        check("s5_no_output", 128'(seen), 128'(0));
        run_small(10'd100, "s5_recover");
        check("small_sb_empty", 128'(sb_s.size()), 128'(0));

        // Scenario 6: default configuration against an R^-1 mod Q reference
        inv2 = (128'(BQ) + 128'd1) >> 1;
        rinv = 128'd1;
        for (int i = 0; i < 64; i++) begin
            rinv = (rinv * inv2) % 128'(BQ);
        end
        for (int i = 0; i < NVEC; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) r = '0;
            else if (i == 1) r = {8'h00, {120{1'b1}}};
            b_in_t     = r[119:0];
            b_in_valid = 1'b1;
            b_out_ready = ($urandom_range(0, 1) != 0);
            n = 0;
            while (!b_in_ready && n < 50) begin
                tick();
                n++;
            end
            if (!b_in_ready) timeout("b_accept");
            tick();
            b_in_valid = 1'b0;
            exp128 = ((128'(b_in_t) % 128'(BQ)) * rinv) % 128'(BQ);
            sb_b.push_back(exp128[59:0]);
            n = 0;
            done = 1'b0;
            while (!done && n < 100) begin
                b_out_ready = ($urandom_range(0, 3) != 0);
                if (b_out_valid && b_out_ready) begin
                    if (sb_b.size() == 0) timeout("b_sb_empty");
                    else check("b_random_out_c", 128'(b_out_c), 128'(sb_b.pop_front()));
                    done = 1'b1;
                end
                tick();
                n++;
            end
            if (!done) timeout("b_out_wait");
        end
        check("big_sb_empty", 128'(sb_b.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
